// File: rtl/div_sequencer.sv
// Radix-2 restoring divide/remainder sequencer (DIV, DIVU, REM, REMU) for the RV32 execute stage.
// Optional macro DIV_SPECIAL_FAST_EN: divisor-zero and signed-overflow results are produced in one cycle.
module div_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            start_i,
  input  logic            kill_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] aRaw_q, aRaw_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            isRem_q, isRem_d;
  logic            signQ_q, signQ_d;
  logic            signR_q, signR_d;
  logic            divZero_q, divZero_d;
  logic            ovf_q, ovf_d;

  logic            accept;
  logic            isSignedIn;
  logic            divZeroIn;
  logic            ovfIn;
  logic            fastHit;
  logic [XLEN-1:0] absA;
  logic [XLEN-1:0] absB;
  logic [XLEN:0]   remShift;
  logic [XLEN:0]   diff;
  logic [XLEN-1:0] quoFinal;
  logic [XLEN-1:0] remFinal;

  function automatic logic [XLEN-1:0] specialResult(input logic isRem, input logic divZero,
                                                    input logic [XLEN-1:0] aRaw);
    if (divZero) return isRem ? aRaw : '1;
    return isRem ? '0 : MIN_NEG;
  endfunction

  assign accept     = start_i & funct3_i[2] & ~kill_i;
  assign isSignedIn = ~funct3_i[0];
  assign divZeroIn  = (b_i == '0);
  assign ovfIn      = isSignedIn & (a_i == MIN_NEG) & (b_i == '1);
  assign absA       = (isSignedIn & a_i[XLEN-1]) ? -a_i : a_i;
  assign absB       = (isSignedIn & b_i[XLEN-1]) ? -b_i : b_i;

`ifdef DIV_SPECIAL_FAST_EN
  assign fastHit = divZeroIn | ovfIn;
`else
  assign fastHit = 1'b0;
`endif

  // The dividend drains out of the quotient register's MSB as quotient bits shift in at the LSB.
  assign remShift = {rem_q, quo_q[XLEN-1]};
  assign diff     = remShift - {1'b0, dvs_q};
  assign quoFinal = signQ_q ? -quo_q : quo_q;
  assign remFinal = signR_q ? -rem_q : rem_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    aRaw_d    = aRaw_q;
    result_d  = result_q;
    isRem_d   = isRem_q;
    signQ_d   = signQ_q;
    signR_d   = signR_q;
    divZero_d = divZero_q;
    ovf_d     = ovf_q;
    stall_o   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          stall_o   = 1'b1;
          rem_d     = '0;
          quo_d     = absA;
          dvs_d     = absB;
          aRaw_d    = a_i;
          isRem_d   = funct3_i[1];
          signQ_d   = isSignedIn & (a_i[XLEN-1] ^ b_i[XLEN-1]);
          signR_d   = isSignedIn & a_i[XLEN-1];
          divZero_d = divZeroIn;
          ovf_d     = ovfIn;
          if (fastHit) begin
            result_d = specialResult(funct3_i[1], divZeroIn, a_i);
            state_d  = DONE;
          end else begin
            cnt_d   = CW'(XLEN-1);
            state_d = RUN;
          end
        end
      end
      RUN: begin
        stall_o = 1'b1;
        if (kill_i) begin
          state_d = IDLE;
        end else begin
          if (!diff[XLEN]) begin
            rem_d = diff[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b1};
          end else begin
            rem_d = remShift[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b0};
          end
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == '0) state_d = FIX;
        end
      end
      FIX: begin
        stall_o = 1'b1;
        if (kill_i) begin
          state_d = IDLE;
        end else begin
          // Sign correction alone gives the wrong DIV-by-zero answer, so special cases override it.
          if (divZero_q || ovf_q) result_d = specialResult(isRem_q, divZero_q, aRaw_q);
          else                    result_d = isRem_q ? remFinal : quoFinal;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      aRaw_q    <= '0;
      result_q  <= '0;
      isRem_q   <= 1'b0;
      signQ_q   <= 1'b0;
      signR_q   <= 1'b0;
      divZero_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      aRaw_q    <= aRaw_d;
      result_q  <= result_d;
      isRem_q   <= isRem_d;
      signQ_q   <= signQ_d;
      signR_q   <= signR_d;
      divZero_q <= divZero_d;
      ovf_q     <= ovf_d;
    end
  end

  assign busy_o   = (state_q == RUN) || (state_q == FIX);
  assign done_o   = (state_q == DONE);
  assign result_o = result_q;

endmodule
